// File: rtl/tmds_gearbox.sv
// tmds_gearbox: bit-clock TMDS gearbox turning 10-bit tokens into per-channel ODDR2 even/odd bit pairs
module tmds_gearbox #(
    parameter int    CHANNELS  = 3,
    parameter string MODE      = "DDR",
    parameter bit    INVERT    = 1'b1,
    parameter bit    LSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [10*CHANNELS-1:0]  tokens,
    input  logic [1:0]              pattern_sel,
    input  logic                    bitslip,
    output logic                    load,
    output logic [CHANNELS-1:0]     out_even,
    output logic [CHANNELS-1:0]     out_odd
);
    localparam int RATIO = (MODE == "DDR") ? 5 : 10;
    localparam int STEP = 10 / RATIO;
    localparam logic [3:0] LAST = 4'(RATIO - 1);
    localparam logic [3:0] PRE = 4'(RATIO - 2);

    logic [3:0] phase_q, phase_d;
    logic stall_q, stall_d, pend_q, pend_d, load_q, load_d;
    logic [9:0] ramp_q;
    logic [9:0] sr_q [CHANNELS];
    logic [9:0] word [CHANNELS];
    logic [CHANNELS-1:0] even_q, odd_q;

    function automatic logic [9:0] prep(input logic [9:0] raw);
        logic [9:0] w;
        w = INVERT ? ~raw : raw;
        prep = w;
        for (int b = 0; b < 10; b++)
            if (!LSB_FIRST) prep[b] = w[9 - b];
    endfunction

    // phase sequencing; a pending slip stretches the last phase into a stall cycle followed by the load cycle
    always_comb begin
        pend_d  = stall_q ? 1'b0 : (pend_q | bitslip);
        stall_d = (phase_q == PRE) && (pend_q | bitslip);
        phase_d = stall_q ? phase_q : (phase_q == LAST) ? 4'd0 : phase_q + 4'd1;
        load_d  = (phase_d == LAST) && !stall_d;
    end

    // word selection per channel, then inversion and bit ordering
    always_comb begin
        for (int n = 0; n < CHANNELS; n++)
            word[n] = prep(pattern_sel == 2'b00 ? tokens[10*n +: 10] :
                           pattern_sel == 2'b01 ? 10'b1111100000 :
                           pattern_sel == 2'b10 ? 10'h155 : ramp_q);
    end

    // phase, slip and ramp state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 4'd0;
            stall_q <= 1'b0;
            pend_q  <= 1'b0;
            load_q  <= 1'b0;
            ramp_q  <= 10'd0;
        end else begin
            phase_q <= phase_d;
            stall_q <= stall_d;
            pend_q  <= pend_d;
            load_q  <= load_d;
            if (load_q) ramp_q <= ramp_q + 10'd1;
        end
    end

    // shift registers: reload on load, hold during a slip stall, otherwise shift out STEP bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < CHANNELS; n++) sr_q[n] <= 10'd0;
            even_q <= '0;
            odd_q  <= '0;
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (load_q) begin
                    sr_q[n]   <= word[n] >> STEP;
                    even_q[n] <= word[n][0];
                    odd_q[n]  <= word[n][STEP-1];
                end else if (!stall_q) begin
                    sr_q[n]   <= sr_q[n] >> STEP;
                    even_q[n] <= sr_q[n][0];
                    odd_q[n]  <= sr_q[n][STEP-1];
                end
            end
        end
    end

    assign load     = load_q;
    assign out_even = even_q;
    assign out_odd  = odd_q;
endmodule
